// File: rtl/psum_reduce_accum_pkg.sv
// Shared widths, saturation limits and FSM encoding for the partial-sum reduce/accumulate block.
package psum_reduce_accum_pkg;

    localparam int LANES = 8;
    localparam int IN_W  = 16;
    localparam int ACC_W = 32;
    localparam int CNT_W = 8;

    localparam logic [ACC_W-1:0] MAX_ACC = 32'h7FFF_FFFF;
    localparam logic [ACC_W-1:0] MIN_ACC = 32'h8000_0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/psum_reduce_accum_tree_stage.sv
// One registered pairwise-add level: N signed W-bit inputs become N/2 signed (W+1)-bit sums.
module psum_tree_stage #(
    parameter int N = 8,
    parameter int W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [N*W-1:0]             in_data,
    output logic                       out_valid,
    output logic [(N/2)*(W+1)-1:0]     out_data
);

    localparam int M  = N / 2;
    localparam int OW = W + 1;

    logic [M*OW-1:0] sum;

    // One extra bit per level keeps the pair sum exact.
    always_comb begin
        sum = '0;
        for (int i = 0; i < M; i++) begin
            sum[i*OW +: OW] = {in_data[2*i*W + W - 1], in_data[2*i*W +: W]}
                            + {in_data[(2*i+1)*W + W - 1], in_data[(2*i+1)*W +: W]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid & ~clear;
            if (in_valid) begin
                out_data <= sum;
            end
        end
    end

endmodule

// File: rtl/psum_reduce_accum.sv
// Reduces 8 partial sums per beat through a 3-level tree and accumulates a tile of beats
// into a saturating accumulator, emitting one result pulse per tile.
module psum_reduce_accum #(
    parameter int LANES = psum_reduce_accum_pkg::LANES,
    parameter int IN_W  = psum_reduce_accum_pkg::IN_W,
    parameter int ACC_W = psum_reduce_accum_pkg::ACC_W,
    parameter int CNT_W = psum_reduce_accum_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [LANES*IN_W-1:0]   in_sums,
    input  logic [CNT_W-1:0]        acc_len,
    input  logic                    clear,
    output logic                    out_valid,
    output logic [ACC_W-1:0]        out_acc,
    output logic                    out_ovf,
    output logic                    busy,
    output logic                    fsm_state
);

    import psum_reduce_accum_pkg::*;

    // Handshake: in_valid marks a beat that is always taken (no ready); out_valid is a
    // one-cycle pulse the consumer must accept; clear outranks in_valid.
    localparam int S1_W = IN_W + 1;
    localparam int S2_W = IN_W + 2;
    localparam int S3_W = IN_W + 3;

    // Narrower accumulators reuse the 32-bit limits shifted down arithmetically.
    localparam int SAT_SHIFT = psum_reduce_accum_pkg::ACC_W - ACC_W;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'($signed(MAX_ACC) >>> SAT_SHIFT);
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'($signed(MIN_ACC) >>> SAT_SHIFT);

    logic                        v1, v2, v3;
    logic [(LANES/2)*S1_W-1:0]   s1;
    logic [(LANES/4)*S2_W-1:0]   s2;
    logic [S3_W-1:0]             s3;
    logic [CNT_W-1:0]            l1, l2, l3;

    psum_tree_stage #(.N(LANES), .W(IN_W)) u_stage1 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_data(in_sums), .out_valid(v1), .out_data(s1)
    );

    psum_tree_stage #(.N(LANES/2), .W(S1_W)) u_stage2 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(v1), .in_data(s1), .out_valid(v2), .out_data(s2)
    );

    psum_tree_stage #(.N(LANES/4), .W(S2_W)) u_stage3 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(v2), .in_data(s2), .out_valid(v3), .out_data(s3)
    );

    // Tile length travels with its beat so only the first beat's acc_len matters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l1 <= '0;
            l2 <= '0;
            l3 <= '0;
        end else begin
            if (in_valid) l1 <= acc_len;
            if (v1)       l2 <= l1;
            if (v2)       l3 <= l2;
        end
    end

    state_t              state, state_n;
    logic [ACC_W-1:0]    acc, acc_n;
    logic [CNT_W-1:0]    cnt, cnt_n, len, len_n;
    logic                sticky, sticky_n;
    logic                emit, emit_ovf;

    logic [ACC_W:0]      base, s3_ext, sum;
    logic                beat_ovf, sticky_acc;
    logic [ACC_W-1:0]    sat_val;
    logic [CNT_W-1:0]    first_len, len_use, cnt_inc;

    assign base       = (state == ST_ACCUM) ? {acc[ACC_W-1], acc} : '0;
    assign s3_ext     = {{(ACC_W + 1 - S3_W){s3[S3_W-1]}}, s3};
    assign sum        = base + s3_ext;
    assign beat_ovf   = sum[ACC_W] ^ sum[ACC_W-1];
    assign sat_val    = beat_ovf ? (sum[ACC_W] ? SAT_MIN : SAT_MAX) : sum[ACC_W-1:0];
    assign sticky_acc = ((state == ST_ACCUM) & sticky) | beat_ovf;
    assign first_len  = (l3 == '0) ? CNT_W'(1) : l3;
    assign len_use    = (state == ST_IDLE) ? first_len : len;
    assign cnt_inc    = ((state == ST_IDLE) ? '0 : cnt) + CNT_W'(1);

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        len_n    = len;
        sticky_n = sticky;
        emit     = 1'b0;
        emit_ovf = 1'b0;
        if (v3) begin
            acc_n    = sat_val;
            cnt_n    = cnt_inc;
            sticky_n = sticky_acc;
            state_n  = ST_ACCUM;
            if (state == ST_IDLE) begin
                len_n = first_len;
            end
            if (cnt_inc == len_use) begin
                emit     = 1'b1;
                emit_ovf = sticky_acc;
                acc_n    = '0;
                cnt_n    = '0;
                sticky_n = 1'b0;
                state_n  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            len       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            len       <= len_n;
            sticky    <= sticky_n;
            out_valid <= emit;
            out_ovf   <= emit & emit_ovf;
            if (emit) begin
                out_acc <= sat_val;
            end
        end
    end

    assign busy      = v1 | v2 | v3 | (state == ST_ACCUM);
    assign fsm_state = (state == ST_ACCUM);

endmodule

// File: tb/tb_psum_reduce_accum.sv
// Bench for psum_reduce_accum: a 32-bit and a 24-bit accumulator instance share stimulus;
// a tile-level reference model feeds expected-result queues checked by a negedge monitor.
module tb_psum_reduce_accum;

    localparam int LANES = 8;
    localparam int IN_W  = 16;
    localparam int SW    = LANES * IN_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          clear    = 1'b0;
    logic [SW-1:0] in_sums  = '0;
    logic [7:0]    acc_len  = '0;

    logic        ov_a, ovf_a, busy_a, st_a;
    logic [31:0] acc_a;
    logic        ov_b, ovf_b, busy_b, st_b;
    logic [23:0] acc_b;

    always #5 clk = ~clk;

    psum_reduce_accum dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sums(in_sums),
        .acc_len(acc_len), .clear(clear), .out_valid(ov_a), .out_acc(acc_a),
        .out_ovf(ovf_a), .busy(busy_a), .fsm_state(st_a)
    );

    psum_reduce_accum #(.ACC_W(24)) dut24 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sums(in_sums),
        .acc_len(acc_len), .clear(clear), .out_valid(ov_b), .out_acc(acc_b),
        .out_ovf(ovf_b), .busy(busy_b), .fsm_state(st_b)
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Expected pulse: {edge index[15:0], ovf, acc[31:0]}
    logic [48:0] exp_q[$];
    logic [48:0] exp24_q[$];

    typedef struct {
        longint     sum;
        logic [7:0] alen;
        int         e;
    } beat_t;
    beat_t pend_q[$];

    int     t_cnt = 0;
    int     t_len = 0;
    longint t_acc[2];
    bit     t_ovf[2];
    bit     busy_exp = 1'b0;
    bit     busy_nxt = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d edge=%0d", name, act, exp, edge_n);
        end
    endtask

    function automatic longint lane_sum(input logic [SW-1:0] s);
        longint r = 0;
        for (int i = 0; i < LANES; i++) r += longint'($signed(s[i*IN_W +: IN_W]));
        return r;
    endfunction

    function automatic longint sat(input longint v, input int w, output bit o);
        longint mx = (longint'(1) << (w - 1)) - 1;
        longint mn = -(longint'(1) << (w - 1));
        o = 1'b0;
        if (v > mx) begin o = 1'b1; return mx; end
        if (v < mn) begin o = 1'b1; return mn; end
        return v;
    endfunction

    function automatic logic [SW-1:0] fill(input logic [15:0] v);
        return {LANES{v}};
    endfunction

    // A beat sampled at edge e lands in the accumulator at edge e+3.
    task automatic commit(input beat_t b, input int k);
        bit o;
        if (t_cnt == 0) begin
            t_len = (b.alen == 0) ? 1 : int'(b.alen);
            t_acc[0] = 0; t_acc[1] = 0;
            t_ovf[0] = 0; t_ovf[1] = 0;
        end
        t_acc[0] = sat(t_acc[0] + b.sum, 32, o); t_ovf[0] |= o;
        t_acc[1] = sat(t_acc[1] + b.sum, 24, o); t_ovf[1] |= o;
        t_cnt++;
        if (t_cnt == t_len) begin
            exp_q.push_back({16'(k), t_ovf[0], 32'(t_acc[0])});
            exp24_q.push_back({16'(k), t_ovf[1], 32'(t_acc[1])});
            t_cnt = 0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input logic [SW-1:0] s,
                              input logic [7:0] l, input bit c);
        beat_t b;
        if (c) begin
            pend_q.delete();
            t_cnt = 0;
        end else begin
            if (pend_q.size() > 0 && pend_q[0].e == k - 3) begin
                b = pend_q.pop_front();
                commit(b, k);
            end
            if (v) begin
                b.sum = lane_sum(s); b.alen = l; b.e = k;
                pend_q.push_back(b);
            end
        end
        busy_nxt = (pend_q.size() != 0) || (t_cnt != 0);
    endtask

    task automatic cycle(input bit v, input logic [SW-1:0] s, input logic [7:0] l, input bit c);
        in_valid = v; in_sums = s; acc_len = l; clear = c;
        model_step(edge_n + 1, v, s, l, c);
        @(posedge clk);
        edge_n++;
        busy_exp = busy_nxt;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 8'd0, 1'b0);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; clear = 1'b0; reset = 1'b0;
        #1;
        check("rst_valid_a", longint'(ov_a), 0);
        check("rst_acc_a", longint'(acc_a), 0);
        check("rst_ovf_a", longint'(ovf_a), 0);
        check("rst_busy_a", longint'(busy_a), 0);
        check("rst_state_a", longint'(st_a), 0);
        check("rst_valid_b", longint'(ov_b), 0);
        check("rst_acc_b", longint'(acc_b), 0);
        check("rst_busy_b", longint'(busy_b), 0);
        exp_q.delete(); exp24_q.delete(); pend_q.delete();
        t_cnt = 0; busy_exp = 1'b0; busy_nxt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            edge_n++;
        end
        #1 reset = 1'b1;
    endtask

    task automatic check_pulse(input string tag, input logic v, input longint act_acc,
                               input logic act_ovf, input bit narrow);
        logic [48:0] e;
        bit empty;
        if (!v) return;
        empty = narrow ? (exp24_q.size() == 0) : (exp_q.size() == 0);
        if (empty) begin
            checks++;
            failures++;
            $display("FAIL %s_spurious actual=pulse(%0d) expected=no_pulse edge=%0d", tag, act_acc, edge_n);
            return;
        end
        if (narrow) e = exp24_q.pop_front();
        else        e = exp_q.pop_front();
        check({tag, "_acc"}, act_acc, longint'($signed(e[31:0])));
        check({tag, "_ovf"}, longint'(act_ovf), longint'(e[32]));
        check({tag, "_edge"}, longint'(edge_n), longint'(e[48:33]));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check_pulse("out32", ov_a, longint'($signed(acc_a)), ovf_a, 1'b0);
            check_pulse("out24", ov_b, longint'($signed(acc_b)), ovf_b, 1'b1);
            check("busy_a", longint'(busy_a), longint'(busy_exp));
            check("busy_b", longint'(busy_b), longint'(busy_exp));
        end
    end

    initial begin
        logic [SW-1:0] rs;
        #2;
        apply_reset();

        // Single beat, length 1: 8 x 100
        cycle(1'b1, fill(16'd100), 8'd1, 1'b0);
        idle(5);

        // Four beats 1..4; acc_len after the first beat is noise
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, fill(16'(i)), (i == 1) ? 8'd4 : 8'($urandom_range(0, 255)), 1'b0);
        idle(5);

        // Signed tiles back to back: 3 x -262144, then 2 x -262144
        for (int i = 0; i < 3; i++) cycle(1'b1, fill(16'h8000), 8'd3, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, fill(16'h8000), 8'd2, 1'b0);
        idle(5);

        // Longest tiles: positive and negative extremes (saturate the 24-bit instance)
        for (int i = 0; i < 255; i++) cycle(1'b1, fill(16'h7FFF), 8'd255, 1'b0);
        for (int i = 0; i < 255; i++) cycle(1'b1, fill(16'h8000), 8'd255, 1'b0);
        idle(5);

        // Gapped tile: beats at 0, 5, 6
        cycle(1'b1, fill(16'd1), 8'd3, 1'b0);
        idle(4);
        cycle(1'b1, fill(16'd1), 8'd3, 1'b0);
        cycle(1'b1, fill(16'd1), 8'd3, 1'b0);
        idle(5);

        // Clear two cycles after the second beat, with a beat riding on the clear
        cycle(1'b1, fill(16'd1), 8'd4, 1'b0);
        cycle(1'b1, fill(16'd1), 8'd4, 1'b0);
        idle(1);
        cycle(1'b1, fill(16'd5), 8'd1, 1'b1);
        cycle(1'b1, fill(16'd2), 8'd1, 1'b0);
        idle(5);

        // acc_len = 0 behaves as 1
        cycle(1'b1, fill(16'd3), 8'd0, 1'b0);
        idle(5);

        // Random traffic with gaps, short tiles and occasional clears
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < LANES; j++) rs[j*IN_W +: IN_W] = 16'($urandom);
            cycle(($urandom_range(0, 3) != 0), rs, 8'($urandom_range(0, 5)),
                  ($urandom_range(0, 49) == 0));
        end
        idle(6);

        // Reset in the middle of a tile, then a fresh 2-beat tile of ones
        cycle(1'b1, fill(16'd1), 8'd3, 1'b0);
        cycle(1'b1, fill(16'd1), 8'd3, 1'b0);
        apply_reset();
        cycle(1'b1, fill(16'd1), 8'd2, 1'b0);
        cycle(1'b1, fill(16'd1), 8'd2, 1'b0);
        idle(8);

        check("exp_q_drained", longint'(exp_q.size()), 0);
        check("exp24_q_drained", longint'(exp24_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
